// File: rtl/fetch_branch_unit.sv
// Fetch PC sequencer with label-table branch/jump resolution for the 8-bit lab CPU.
// All outputs registered; taken transfers insert FLUSH_CYCLES bubbles before the target fetch.
module fetch_branch_unit #(
  parameter int PC_W         = 10,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            halt_i,
  input  logic [7:0]      regA_i,
  input  logic [7:0]      regB_i,
  input  logic            lt_we_i,
  input  logic [3:0]      lt_addr_i,
  input  logic [PC_W-1:0] lt_wdata_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            done_o,
  output logic [7:0]      taken_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_t;

  state_t          state;
  logic [1:0]      flush_left;
  logic [PC_W-1:0] lbl_tab [16];

  logic            taken;
  logic [PC_W-1:0] target;

  assign taken  = jump_i | (branch_i & (regB_i != 8'd0));
  assign target = lbl_tab[regA_i[3:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_left    <= 2'd0;
      pc_o          <= '0;
      fetch_valid_o <= 1'b0;
      flush_o       <= 1'b0;
      done_o        <= 1'b0;
      taken_count_o <= 8'd0;
      for (int i = 0; i < 16; i++) lbl_tab[i] <= '0;
    end else begin
      // Lookups above see the pre-write value because of nonblocking update.
      if (lt_we_i) lbl_tab[lt_addr_i] <= lt_wdata_i;

      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= RUN;
            pc_o          <= '0;
            fetch_valid_o <= 1'b1;
          end
        end
        RUN: begin
          if (stall_i) begin
            state <= RUN;
          end else if (halt_i) begin
            state         <= HALTED;
            fetch_valid_o <= 1'b0;
            done_o        <= 1'b1;
          end else if (taken) begin
            state         <= FLUSH;
            pc_o          <= target;
            fetch_valid_o <= 1'b0;
            flush_o       <= 1'b1;
            flush_left    <= 2'(FLUSH_CYCLES - 1);
            if (taken_count_o != 8'hFF) taken_count_o <= taken_count_o + 8'd1;
          end else begin
            pc_o <= pc_o + PC_W'(1);
          end
        end
        FLUSH: begin
          if (flush_left == 2'd0) begin
            state         <= RUN;
            flush_o       <= 1'b0;
            fetch_valid_o <= 1'b1;
          end else begin
            flush_left <= flush_left - 2'd1;
          end
        end
        HALTED: begin
          if (start_i) begin
            state         <= RUN;
            pc_o          <= '0;
            done_o        <= 1'b0;
            fetch_valid_o <= 1'b1;
            taken_count_o <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed plus random bench for fetch_branch_unit against a cycle-level behavioural model.
module tb_fetch_branch_unit;
  localparam int PC_W = 10;
  localparam int FC   = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i, stall_i, branch_i, jump_i, halt_i, lt_we_i;
  logic [7:0]      regA_i, regB_i;
  logic [3:0]      lt_addr_i;
  logic [PC_W-1:0] lt_wdata_i;
  logic [PC_W-1:0] pc_o;
  logic            fetch_valid_o, flush_o, done_o;
  logic [7:0]      taken_count_o;

  fetch_branch_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .jump_i(jump_i), .halt_i(halt_i),
    .regA_i(regA_i), .regB_i(regB_i), .lt_we_i(lt_we_i),
    .lt_addr_i(lt_addr_i), .lt_wdata_i(lt_wdata_i), .pc_o(pc_o),
    .fetch_valid_o(fetch_valid_o), .flush_o(flush_o), .done_o(done_o),
    .taken_count_o(taken_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 running, 2 bubbling, 3 halted.
  int m_mode, m_pc, m_cnt, m_fl;
  int m_tab [16];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    int'(pc_o),          m_pc);
    chk({tag, ".valid"}, int'(fetch_valid_o), int'(m_mode == 1));
    chk({tag, ".flush"}, int'(flush_o),       int'(m_mode == 2));
    chk({tag, ".done"},  int'(done_o),        int'(m_mode == 3));
    chk({tag, ".count"}, int'(taken_count_o), m_cnt);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cnt = 0; m_fl = 0;
    for (int i = 0; i < 16; i++) m_tab[i] = 0;
  endtask

  task automatic model_next();
    bit tk;
    int tgt;
    tk  = jump_i || (branch_i && regB_i != 0);
    tgt = m_tab[regA_i % 16];
    case (m_mode)
      0: if (start_i) begin m_mode = 1; m_pc = 0; end
      1: begin
        if (stall_i) ;
        else if (halt_i) m_mode = 3;
        else if (tk) begin
          m_pc = tgt; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_mode = 2; m_fl = FC;
        end else m_pc = (m_pc + 1) % (1 << PC_W);
      end
      2: begin m_fl--; if (m_fl == 0) m_mode = 1; end
      default: if (start_i) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    endcase
    if (lt_we_i) m_tab[lt_addr_i] = int'(lt_wdata_i);
  endtask

  task automatic clr();
    start_i = 0; stall_i = 0; branch_i = 0; jump_i = 0; halt_i = 0;
    lt_we_i = 0; regA_i = 0; regB_i = 0; lt_addr_i = 0; lt_wdata_i = 0;
  endtask

  // Inputs are set at a negedge, the model advances, then outputs are checked at the next negedge.
  task automatic tick(input string tag);
    model_next();
    @(negedge clk);
    check_all(tag);
    clr();
  endtask

  task automatic wr(input int idx, input int val);
    lt_we_i = 1; lt_addr_i = 4'(idx); lt_wdata_i = PC_W'(val);
  endtask

  initial begin
    clr();
    rst_n = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    // Start and free-run.
    wr(3, 'h155); tick("wr3");
    start_i = 1; tick("start");
    for (int i = 0; i < 7; i++) tick("run");
    chk("pc_at7", int'(pc_o), 7);

    // Taken branch through table[3].
    branch_i = 1; regA_i = 8'h03; regB_i = 8'h01; tick("br_taken");
    chk("br_pc", int'(pc_o), 'h155);
    chk("br_flush", int'(flush_o), 1);
    tick("br_after");
    chk("br_valid", int'(fetch_valid_o), 1);
    chk("br_count", int'(taken_count_o), 1);

    // Not-taken branch, then stall masking a jump.
    branch_i = 1; regA_i = 8'h03; regB_i = 8'h00; tick("br_nt");
    stall_i = 1; jump_i = 1; regA_i = 8'h03; tick("stall_jump");

    // Wrap at the top of the PC range.
    wr(1, 'h3FF); tick("wr1");
    jump_i = 1; regA_i = 8'h01; tick("j3ff");
    tick("j3ff_fl");
    chk("pc_3ff", int'(pc_o), 'h3FF);
    tick("wrap");
    chk("pc_wrap", int'(pc_o), 0);

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin
      jump_i = 1; regA_i = 8'h01; tick("jmany");
      tick("jmany_fl");
    end
    chk("count_sat", int'(taken_count_o), 255);

    // Halt at 0x20, then restart.
    wr(2, 'h20); tick("wr2");
    jump_i = 1; regA_i = 8'h02; tick("j20");
    tick("j20_fl");
    halt_i = 1; tick("halt");
    for (int i = 0; i < 10; i++) begin
      branch_i = 1; regB_i = 8'h01; tick("halted");
    end
    chk("halt_pc", int'(pc_o), 'h20);
    chk("halt_done", int'(done_o), 1);
    start_i = 1; tick("restart");
    chk("restart_count", int'(taken_count_o), 0);

    // Write/lookup collision uses the old entry; upper regA bits ignored.
    wr(5, 'h0AA); tick("wr5");
    wr(5, 'h111); jump_i = 1; regA_i = 8'h25; tick("collide");
    chk("collide_pc", int'(pc_o), 'h0AA);

    // Async reset while bubbling.
    chk("in_flush", int'(flush_o), 1);
    #2 rst_n = 0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    tick("post_rst");
    jump_i = 1; regA_i = 8'h05; start_i = 1; tick("tab_cleared");
    tick("tab_cleared2");

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      start_i  = ($urandom_range(0, 19) == 0);
      stall_i  = ($urandom_range(0, 4) == 0);
      branch_i = ($urandom_range(0, 5) == 0);
      jump_i   = ($urandom_range(0, 9) == 0);
      halt_i   = ($urandom_range(0, 39) == 0);
      regA_i   = 8'($urandom);
      regB_i   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      lt_we_i  = ($urandom_range(0, 4) == 0);
      lt_addr_i  = 4'($urandom);
      lt_wdata_i = PC_W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        clr();
        rst_n = 0;
        model_reset();
        #1 check_all("rnd_rst");
        @(negedge clk);
        rst_n = 1;
      end else begin
        tick("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
